ipbb_rst_seq: RTL and testbench
===============================

# ipbb_rst_seq

Staged reset-release sequencer for the PTP bridge. It consumes the synchronized reset produced by the bridge's async-to-sync reset stage and releases NUM_STAGES downstream reset domains one at a time, in index order. Each release waits for that stage's ready acknowledgement, bounded by a timeout. A software soft-reset request re-runs the whole sequence without a global reset.

## Interface
Parameters:
- NUM_STAGES, 3: number of sequenced reset outputs; legal range 1..8.
- HOLD_CYCLES, 16: cycles all outputs stay asserted after reset/soft-reset before stage 0 releases; must be at least 1.
- TIMEOUT_CYCLES, 1024: maximum wait for ready_in[i] before forcing progress; must be at least 1.

Ports:
- clk  in  1  single clock domain for all logic.
- syn_rst  in  1  synchronous, active-high reset.
- sw_rst_req  in  1  single-cycle soft-reset request; a level is treated as repeated requests.
- ready_in  in  NUM_STAGES  per-stage "out of reset and ready" acknowledgement.
- rst_out  out  NUM_STAGES  per-stage active-high reset, registered.
- seq_done  out  1  high once all stages are released.
- timeout_err  out  NUM_STAGES  sticky per-stage timeout flag.
- busy  out  1  high while the sequence is in progress (HOLD or WAIT).

## Operation
- States: HOLD, WAIT, DONE. The stage index idx has width $clog2(NUM_STAGES) with a minimum of 1. Counter cnt has width $clog2(max(HOLD_CYCLES,TIMEOUT_CYCLES)+1).
- syn_rst=1 takes priority over everything and sets:
  - state=HOLD, cnt=0, idx=0.
  - rst_out all ones, seq_done=0, busy=1, timeout_err=0.
- HOLD:
  - cnt increments each cycle.
  - When cnt==HOLD_CYCLES-1: clear rst_out[0], cnt=0, idx=0, go to WAIT.
  - ready_in is ignored.
- WAIT (stage idx is released and awaits its ack):
  - If ready_in[idx]=1: the stage is acknowledged.
  - Else if cnt==TIMEOUT_CYCLES-1: set timeout_err[idx] and treat the stage as acknowledged.
  - Else cnt increments.
  - On acknowledge with idx<NUM_STAGES-1: clear rst_out[idx+1], idx increments, cnt=0, stay in WAIT.
  - On acknowledge with idx==NUM_STAGES-1: go to DONE, seq_done=1, busy=0.
- DONE: all rst_out low and seq_done=1 until a soft reset or syn_rst.
- sw_rst_req=1 (with syn_rst=0), in any state:
  - Next cycle: rst_out all ones, seq_done=0, busy=1, state=HOLD, cnt=0, idx=0.
  - timeout_err is preserved; only syn_rst clears it.
  - A request takes priority over a same-cycle ack or timeout, which is discarded.
- Released stages never re-assert except via sw_rst_req or syn_rst.
- ready_in bits for stages other than idx are ignored. A stage that drops ready after acknowledgement has no effect.

## Timing
- Reset values: rst_out all ones, seq_done=0, timeout_err=0, busy=1.
- Let cycle 1 be the first cycle with syn_rst=0. rst_out[0] falls at the clock edge ending cycle HOLD_CYCLES and is low in cycle HOLD_CYCLES+1.
- Release chain:
  - ready_in[i] is sampled from the first cycle in which rst_out[i] is low.
  - If it is high in that cycle, rst_out[i+1] is low the following cycle.
  - With ready_in tied high, stages release on consecutive cycles.
  - seq_done rises one cycle after rst_out[NUM_STAGES-1] falls.
- Timeout: if stage i is never ready, timeout_err[i] and the release of stage i+1 (or seq_done) appear TIMEOUT_CYCLES cycles after rst_out[i] falls.
- sw_rst_req sampled in cycle k: outputs re-asserted in cycle k+1. The HOLD count restarts from k+1, with the same timing as for syn_rst.
- All outputs are registered; there is no combinational path from any input to any output.

## Test plan
- Defaults with ready_in=3'b111 and syn_rst low from cycle 1 -> rst_out 3'b111 through cycle 16; 3'b110 at cycle 17, 3'b100 at 18, 3'b000 at 19; seq_done=1 at 20; timeout_err=0.
- Defaults, ready_in[1] rises 5 cycles after rst_out[1] falls -> rst_out[2] falls exactly one cycle after ready_in[1] is first sampled high; busy=1 throughout; seq_done follows.
- TIMEOUT_CYCLES=8 with ready_in[1] stuck low -> timeout_err=3'b010 exactly 8 cycles after rst_out[1] falls; stage 2 released on that cycle; seq_done=1; timeout_err stays set after a subsequent sw_rst_req.
- sw_rst_req pulse in DONE -> rst_out=3'b111 next cycle, seq_done=0, full sequence replays with identical timing.
- sw_rst_req in the same cycle as the stage-0 ack, with ready_in[0]=1 -> stage 1 stays in reset; rst_out=3'b111; HOLD restarts.
- syn_rst asserted mid-WAIT with timeout_err nonzero -> next cycle all outputs at reset values, including timeout_err=0.

Source files
------------

// File: rtl/ipbb_rst_seq.sv
// ipbb_rst_seq: staged reset-release sequencer.
// Holds every downstream reset domain in reset for a fixed period. It then
// releases the domains one at a time, in index order. Each stage waits for
// its ready acknowledgement, and a timeout bounds that wait. A soft-reset
// request replays the whole sequence. Sticky timeout flags survive a soft
// reset and are cleared only by syn_rst.
module ipbb_rst_seq #(
    parameter int NUM_STAGES     = 3,
    parameter int HOLD_CYCLES    = 16,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                  clk,
    input  logic                  syn_rst,
    input  logic                  sw_rst_req,
    input  logic [NUM_STAGES-1:0] ready_in,
    output logic [NUM_STAGES-1:0] rst_out,
    output logic                  seq_done,
    output logic [NUM_STAGES-1:0] timeout_err,
    output logic                  busy
);

    localparam int IW   = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1;
    localparam int CMAX = (HOLD_CYCLES > TIMEOUT_CYCLES) ? HOLD_CYCLES : TIMEOUT_CYCLES;
    localparam int CW   = $clog2(CMAX + 1);

    localparam logic [1:0] ST_HOLD = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_CYCLES - 1);
    localparam logic [CW-1:0] TMO_LAST  = CW'(TIMEOUT_CYCLES - 1);
    localparam logic [IW-1:0] IDX_LAST  = IW'(NUM_STAGES - 1);

    logic [1:0]            state_q, state_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [IW-1:0]         idx_q, idx_d;
    logic [NUM_STAGES-1:0] rst_out_q, rst_out_d;
    logic                  seq_done_q, seq_done_d;
    logic [NUM_STAGES-1:0] timeout_err_q, timeout_err_d;
    logic                  busy_q, busy_d;

    // sel_oh marks the stage currently awaiting its ack.
    // next_oh marks the stage that is released when that ack arrives.
    logic [NUM_STAGES-1:0] sel_oh;
    logic [NUM_STAGES-1:0] next_oh;
    logic                  ready_sel;
    logic                  ack;

    for (genvar gi = 0; gi < NUM_STAGES; gi++) begin : g_stage
        assign sel_oh[gi] = (idx_q == IW'(gi));
        if (gi == 0) begin : g_first
            assign next_oh[gi] = 1'b0;
        end else begin : g_rest
            assign next_oh[gi] = sel_oh[gi-1];
        end
    end

    // Only the active stage's ready bit matters; all other bits are ignored.
    assign ready_sel = |(ready_in & sel_oh);

    // Next-state logic: hold count, per-stage wait/timeout, and soft-reset override.
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        idx_d         = idx_q;
        rst_out_d     = rst_out_q;
        seq_done_d    = seq_done_q;
        timeout_err_d = timeout_err_q;
        busy_d        = busy_q;
        ack           = 1'b0;

        case (state_q)
            ST_HOLD: begin
                if (cnt_q == HOLD_LAST) begin
                    rst_out_d[0] = 1'b0;
                    cnt_d        = '0;
                    idx_d        = '0;
                    state_d      = ST_WAIT;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_WAIT: begin
                if (ready_sel) begin
                    ack = 1'b1;
                end else if (cnt_q == TMO_LAST) begin
                    // A timeout is flagged, then handled exactly like an ack.
                    ack           = 1'b1;
                    timeout_err_d = timeout_err_q | sel_oh;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
                if (ack) begin
                    cnt_d = '0;
                    if (idx_q == IDX_LAST) begin
                        state_d    = ST_DONE;
                        seq_done_d = 1'b1;
                        busy_d     = 1'b0;
                    end else begin
                        idx_d     = idx_q + 1'b1;
                        rst_out_d = rst_out_q & ~next_oh;
                    end
                end
            end
            ST_DONE: begin
                rst_out_d = '0;
            end
            default: begin
                // Unreachable encoding: restart the sequence from the top.
                state_d    = ST_HOLD;
                cnt_d      = '0;
                idx_d      = '0;
                rst_out_d  = '1;
                seq_done_d = 1'b0;
                busy_d     = 1'b1;
            end
        endcase

        // A soft reset wins over any same-cycle ack or timeout.
        // It keeps the timeout history.
        if (sw_rst_req) begin
            state_d       = ST_HOLD;
            cnt_d         = '0;
            idx_d         = '0;
            rst_out_d     = '1;
            seq_done_d    = 1'b0;
            busy_d        = 1'b1;
            timeout_err_d = timeout_err_q;
        end
    end

    // State registers with synchronous reset to the all-held condition.
    always_ff @(posedge clk) begin
        if (syn_rst) begin
            state_q       <= ST_HOLD;
            cnt_q         <= '0;
            idx_q         <= '0;
            rst_out_q     <= '1;
            seq_done_q    <= 1'b0;
            timeout_err_q <= '0;
            busy_q        <= 1'b1;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            idx_q         <= idx_d;
            rst_out_q     <= rst_out_d;
            seq_done_q    <= seq_done_d;
            timeout_err_q <= timeout_err_d;
            busy_q        <= busy_d;
        end
    end

    assign rst_out     = rst_out_q;
    assign seq_done    = seq_done_q;
    assign timeout_err = timeout_err_q;
    assign busy        = busy_q;

endmodule

// File: tb/tb_ipbb_rst_seq.sv
// Testbench for ipbb_rst_seq: directed vectors, corner-case sequences and
// random stimulus checked against a released-stage-count reference model.
module tb_ipbb_rst_seq;

    localparam int NS   = 3;
    localparam int HOLD = 16;
    localparam int TMO  = 8;
    localparam logic [NS-1:0] ONES = '1;

    logic          clk;
    logic          syn_rst;
    logic          sw_rst_req;
    logic [NS-1:0] ready_in;
    logic [NS-1:0] rst_out;
    logic          seq_done;
    logic [NS-1:0] timeout_err;
    logic          busy;

    int n_checks = 0;
    int n_errors = 0;

    ipbb_rst_seq #(
        .NUM_STAGES    (NS),
        .HOLD_CYCLES   (HOLD),
        .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk        (clk),
        .syn_rst    (syn_rst),
        .sw_rst_req (sw_rst_req),
        .ready_in   (ready_in),
        .rst_out    (rst_out),
        .seq_done   (seq_done),
        .timeout_err(timeout_err),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model state.
    // m_rel   : number of stages already released (0 = still holding).
    // m_phase : cycles spent in the current hold or wait phase.
    bit          m_valid = 1'b0;
    int          m_rel;
    int          m_phase;
    bit          m_done;
    logic [NS-1:0] m_terr;

    task automatic model_update(input logic s_rst, input logic s_sw, input logic [NS-1:0] rdy);
        int s;
        if (s_rst) begin
            m_valid = 1'b1;
            m_rel   = 0;
            m_phase = 0;
            m_done  = 1'b0;
            m_terr  = '0;
        end else if (!m_valid) begin
            // The model starts tracking only after the first syn_rst.
        end else if (s_sw) begin
            m_rel   = 0;
            m_phase = 0;
            m_done  = 1'b0;
        end else if (m_rel == 0) begin
            m_phase++;
            if (m_phase == HOLD) begin
                m_rel   = 1;
                m_phase = 0;
            end
        end else if (!m_done) begin
            s = m_rel - 1;
            if (rdy[s] || m_phase == TMO - 1) begin
                if (!rdy[s]) m_terr[s] = 1'b1;
                if (m_rel == NS) m_done = 1'b1;
                else m_rel++;
                m_phase = 0;
            end else begin
                m_phase++;
            end
        end
    endtask

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Advance one clock edge, update the model, and compare away from the edge.
    task automatic step();
        logic [NS-1:0] e_rst;
        @(posedge clk);
        model_update(syn_rst, sw_rst_req, ready_in);
        #1;
        if (m_valid) begin
            e_rst = ONES << m_rel;
            check("model rst_out", 8'(rst_out), 8'(e_rst));
            check("model seq_done", 8'(seq_done), 8'(m_done));
            check("model busy", 8'(busy), 8'(!m_done));
            check("model timeout_err", 8'(timeout_err), 8'(m_terr));
        end
    endtask

    task automatic wait_rst_low(input int i, input int budget);
        for (int k = 0; k < budget && rst_out[i] !== 1'b0; k++) step();
        n_checks++;
        if (rst_out[i] !== 1'b0) begin
            n_errors++;
            $display("FAIL wait rst_out[%0d] low: got %b, expected 0 within %0d cycles", i, rst_out[i], budget);
        end
    endtask

    task automatic sw_pulse();
        sw_rst_req = 1'b1;
        step();
        sw_rst_req = 1'b0;
    endtask

    typedef struct {
        logic          srst;
        logic          sw;
        logic [NS-1:0] rdy;
        logic [NS-1:0] e_rst;
        logic          e_done;
        logic          e_busy;
        logic [NS-1:0] e_terr;
        int            reps;
    } vec_t;

    vec_t tbl[$];

    initial begin
        syn_rst    = 1'b1;
        sw_rst_req = 1'b0;
        ready_in   = '0;

        // Nominal sequence with ready tied high, then a soft reset from DONE.
        tbl.push_back('{1'b1, 1'b0, 3'b111, 3'b111, 1'b0, 1'b1, 3'b000, 2});
        tbl.push_back('{1'b0, 1'b0, 3'b111, 3'b111, 1'b0, 1'b1, 3'b000, 15});
        tbl.push_back('{1'b0, 1'b0, 3'b111, 3'b110, 1'b0, 1'b1, 3'b000, 1});
        tbl.push_back('{1'b0, 1'b0, 3'b111, 3'b100, 1'b0, 1'b1, 3'b000, 1});
        tbl.push_back('{1'b0, 1'b0, 3'b111, 3'b000, 1'b0, 1'b1, 3'b000, 1});
        tbl.push_back('{1'b0, 1'b0, 3'b111, 3'b000, 1'b1, 1'b0, 3'b000, 3});
        tbl.push_back('{1'b0, 1'b1, 3'b111, 3'b111, 1'b0, 1'b1, 3'b000, 1});
        tbl.push_back('{1'b0, 1'b0, 3'b111, 3'b111, 1'b0, 1'b1, 3'b000, 15});
        tbl.push_back('{1'b0, 1'b0, 3'b111, 3'b110, 1'b0, 1'b1, 3'b000, 1});
        tbl.push_back('{1'b0, 1'b0, 3'b111, 3'b100, 1'b0, 1'b1, 3'b000, 1});
        tbl.push_back('{1'b0, 1'b0, 3'b111, 3'b000, 1'b0, 1'b1, 3'b000, 1});
        tbl.push_back('{1'b0, 1'b0, 3'b111, 3'b000, 1'b1, 1'b0, 3'b000, 2});

        for (int v = 0; v < tbl.size(); v++) begin
            syn_rst    = tbl[v].srst;
            sw_rst_req = tbl[v].sw;
            ready_in   = tbl[v].rdy;
            for (int r = 0; r < tbl[v].reps; r++) begin
                step();
                check($sformatf("vec%0d rst_out", v), 8'(rst_out), 8'(tbl[v].e_rst));
                check($sformatf("vec%0d seq_done", v), 8'(seq_done), 8'(tbl[v].e_done));
                check($sformatf("vec%0d busy", v), 8'(busy), 8'(tbl[v].e_busy));
                check($sformatf("vec%0d timeout_err", v), 8'(timeout_err), 8'(tbl[v].e_terr));
            end
            $display("vec %0d: rst_out=%b seq_done=%b busy=%b timeout_err=%b", v, rst_out, seq_done, busy, timeout_err);
        end
        sw_rst_req = 1'b0;

        // Stage 1 becomes ready 5 cycles after its release.
        ready_in = 3'b101;
        sw_pulse();
        wait_rst_low(1, 40);
        for (int k = 0; k < 5; k++) begin
            step();
            check("late ack rst_out[2] held", 8'(rst_out[2]), 8'd1);
            check("late ack busy", 8'(busy), 8'd1);
        end
        ready_in = 3'b111;
        step();
        check("late ack rst_out[2] released", 8'(rst_out[2]), 8'd0);
        check("late ack busy", 8'(busy), 8'd1);
        step();
        check("late ack seq_done", 8'(seq_done), 8'd1);
        $display("seq late_ack: rst_out=%b seq_done=%b", rst_out, seq_done);

        // Stage 1 never becomes ready, so its wait times out.
        ready_in = 3'b101;
        sw_pulse();
        wait_rst_low(1, 40);
        for (int k = 0; k < TMO - 1; k++) begin
            step();
            check("timeout pending terr", 8'(timeout_err), 8'd0);
            check("timeout pending rst_out[2]", 8'(rst_out[2]), 8'd1);
        end
        step();
        check("timeout terr", 8'(timeout_err), 8'b010);
        check("timeout rst_out", 8'(rst_out), 8'b000);
        step();
        check("timeout seq_done", 8'(seq_done), 8'd1);
        sw_pulse();
        check("sw keeps terr", 8'(timeout_err), 8'b010);
        check("sw rst_out", 8'(rst_out), 8'b111);
        check("sw seq_done", 8'(seq_done), 8'd0);
        $display("seq timeout: timeout_err=%b rst_out=%b", timeout_err, rst_out);

        // syn_rst during a wait clears the sticky flags.
        ready_in = 3'b100;
        wait_rst_low(0, 40);
        syn_rst = 1'b1;
        step();
        syn_rst = 1'b0;
        check("srst mid-wait terr", 8'(timeout_err), 8'd0);
        check("srst mid-wait rst_out", 8'(rst_out), 8'b111);
        check("srst mid-wait busy", 8'(busy), 8'd1);
        check("srst mid-wait seq_done", 8'(seq_done), 8'd0);
        $display("seq srst_mid_wait: timeout_err=%b rst_out=%b", timeout_err, rst_out);

        // Soft reset in the same cycle as the stage-0 ack.
        ready_in = 3'b111;
        wait_rst_low(0, 40);
        sw_pulse();
        check("sw vs ack rst_out", 8'(rst_out), 8'b111);
        for (int k = 0; k < HOLD - 1; k++) begin
            step();
            check("sw vs ack hold", 8'(rst_out), 8'b111);
        end
        step();
        check("sw vs ack re-release", 8'(rst_out), 8'b110);
        $display("seq sw_vs_ack: rst_out=%b", rst_out);

        // Random stimulus against the reference model.
        for (int blk = 0; blk < 20; blk++) begin
            int dens = $urandom_range(1, 4);
            for (int k = 0; k < 200; k++) begin
                syn_rst    = ($urandom_range(0, 399) == 0);
                sw_rst_req = ($urandom_range(0, 149) == 0);
                ready_in   = ($urandom_range(1, 4) <= dens) ? 3'($urandom_range(0, 7)) : 3'b000;
                step();
            end
            $display("random block %0d: rst_out=%b seq_done=%b timeout_err=%b", blk, rst_out, seq_done, timeout_err);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
